exe_div_stage: RTL and testbench
================================

# exe_div_stage

Iterative 32-bit integer divide unit occupying the EX slot for DIV/MOD instructions. It accepts one operation from ID through a valid/allowin handshake and runs a 1-bit-per-cycle restoring divider. It holds the result until MEM accepts it. Throughout, it drives the EX bypass bus so the hazard detector stalls dependent readers while the quotient or remainder is not yet ready and forwards it once it is.

## Interface
Parameters:
- `DIV_ITER`, 32: iteration count; fixed for 32-bit operands.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset. One clock; reset is synchronous and active-low.
- `flush`  in  1  exception/ertn flush; kills the in-flight operation.
- `id_valid`  in  1  ID presents a divide operation.
- `ex_allowin`  out  1  unit can accept this cycle.
- `div_op`  in  2  bit1 = signed, bit0 = remainder (1) / quotient (0).
- `src1`, `src2`  in  32 each  dividend and divisor.
- `id_rf_waddr`  in  5  destination register.
- `id_rf_we`  in  1  destination write enable.
- `ex_to_mem_valid`  out  1  result presented to MEM.
- `mem_allowin`  in  1  MEM accepts this cycle.
- `ex_result`  out  32  final quotient or remainder.
- `ex_rf_waddr`  out  5  latched destination.
- `ex_rf_we`  out  1  latched write enable.
- `EX_bypass_bus`  out  `EX_BYPASS_LEN` (41)  fields, MSB first: {res_from_csr, rf_waddr[4:0], rf_we, mul, res_from_mem, result[31:0]}.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Accept when `id_valid & ex_allowin`.
  - On accept, latch op, waddr and we.
  - Latch operand magnitudes; in signed mode take the two's-complement absolute value.
  - Latch result signs: quotient negative = sign1 ^ sign2; remainder takes the dividend sign.
- IDLE → BUSY on accept. The exception is divisor == 0, which goes IDLE → DONE with no iteration.
- BUSY: each cycle, one shift-subtract step and the 5-bit counter increments. After `DIV_ITER` steps (counter wraps 31 → 0), go BUSY → DONE and apply sign correction.
- DONE: `ex_to_mem_valid` = 1. When `mem_allowin` is high:
  - With a simultaneous new accept, go to BUSY (or DONE on divide-by-zero).
  - Otherwise go to IDLE.
- `ex_allowin` = (state == IDLE) | (state == DONE & mem_allowin).
- Divide by zero: quotient = 0xFFFFFFFF, remainder = `src1` unchanged; this holds for both signed and unsigned.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out of the magnitude path and needs no special case.
- Bypass bus:
  - res_from_csr = 0 and res_from_mem = 0 always.
  - rf_we = (state != IDLE) & latched we.
  - mul = (state == BUSY); this is the "not ready" flag that makes the detector stall.
  - result = `ex_result` in DONE, else 0.
- `flush` has priority over every transition:
  - Next state is IDLE, outputs are invalid, and no accept happens that cycle.
  - `ex_allowin` is forced to 0 while `flush` is high.

## Timing
- Reset (resetn = 0 at an edge): state IDLE, counter 0, every output register 0, `ex_allowin` = 1 the next cycle, bus all-zero.
- Latency:
  - Accept at edge N: BUSY during cycles N+1..N+32, DONE visible from cycle N+33.
  - Divide by zero: DONE at cycle N+1.
- DONE holds `ex_result`, waddr and we stable while `mem_allowin` = 0. There is no limit on how long DONE is held.
- Back-to-back: a DONE handoff and a new accept in the same cycle leave no bubble in the unit.
- Flush or reset mid-BUSY: the partial remainder is discarded. The bus shows rf_we = 0 the cycle after the edge.
- All outputs are registered or derived from state only; there is no combinational path from `src1`/`src2` to any output.

## Structure
- Add to `macro.vh`:
  - `EX_BYPASS_LEN` (41).
  - `DIV_OP_SIGNED` and `DIV_OP_REM` bit indices.
  - State encodings `DIV_IDLE`, `DIV_BUSY`, `DIV_DONE`.
- Sub-module `div_core`: the iterative restoring datapath (dividend/remainder shift register, counter, subtractor). It has start/done handshake and is unsigned-only.
- Sign handling and the FSM/handshake stay in `exe_div_stage`.

## Test plan
- Unsigned 7 / 2, op = 00: at cycle N+33, `ex_result` = 3; the bypass mul bit is 1 for cycles N+1..N+32 and 0 at N+33. Repeat with op = 01: result 1.
- Signed 0xFFFFFFF9 / 2 (−7 / 2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- 5 / 0, signed and unsigned: DONE at N+1; quotient 0xFFFFFFFF, remainder 5.
- Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- `flush` pulsed at cycle N+10: the next cycle is IDLE, rf_we = 0 on the bus, `ex_allowin` = 1, and a subsequent op (9/3) returns 3 correctly.
- `mem_allowin` held 0 for 5 cycles in DONE: the result stays stable and `ex_allowin` = 0. Releasing it with `id_valid` high accepts the next op in the same cycle.

Source files
------------

// File: rtl/exe_div_stage_pkg.sv
// Shared definitions for the EX-stage iterative divider: bypass bus width,
// div_op bit positions, FSM state encoding and a small sign helper.
package exe_div_stage_pkg;

   localparam int EX_BYPASS_LEN = 41;
   localparam int DIV_OP_SIGNED = 1;
   localparam int DIV_OP_REM    = 0;
   localparam int DIV_CNT_W     = 5;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // Two's-complement negate when neg is set, pass through otherwise.
   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/exe_div_stage_div_core.sv
// Unsigned restoring divider: one shift-subtract step per cycle.
// The dividend register shifts quotient bits in from the right, so after the
// last step it holds the quotient while the partial remainder holds the remainder.
module div_core
   import exe_div_stage_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        kill,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        done,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   localparam logic [DIV_CNT_W-1:0] LAST_CNT = DIV_CNT_W'(DIV_ITER - 1);

   logic                 run_q, run_d;
   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]          dvd_q, dvd_d;
   logic [31:0]          rem_q, rem_d;
   logic [31:0]          dsr_q, dsr_d;

   logic [32:0] shifted;
   logic [32:0] diff;
   logic        fits;
   logic [31:0] rem_step;
   logic [31:0] dvd_step;

   // One restoring step plus load/kill control; the step results double as
   // the final quotient/remainder on the cycle done is raised.
   always_comb begin
      run_d    = run_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      rem_d    = rem_q;
      dsr_d    = dsr_q;
      shifted  = {rem_q, dvd_q[31]};
      diff     = shifted - {1'b0, dsr_q};
      fits     = ~diff[32];
      rem_step = fits ? diff[31:0] : shifted[31:0];
      dvd_step = {dvd_q[30:0], fits};
      done     = run_q & (cnt_q == LAST_CNT);
      if (kill) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
         dvd_d = dividend;
         rem_d = 32'd0;
         dsr_d = divisor;
      end else if (run_q) begin
         dvd_d = dvd_step;
         rem_d = rem_step;
         cnt_d = done ? '0 : cnt_q + 1'b1;
         if (done) begin
            run_d = 1'b0;
         end
      end
   end

   assign quotient  = dvd_step;
   assign remainder = rem_step;

   // Datapath and counter registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         dvd_q <= 32'd0;
         rem_q <= 32'd0;
         dsr_q <= 32'd0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         dvd_q <= dvd_d;
         rem_q <= rem_d;
         dsr_q <= dsr_d;
      end
   end

endmodule

// File: rtl/exe_div_stage.sv
// EX-slot wrapper for DIV/MOD: ID/MEM handshake, sign handling around the
// unsigned core, divide-by-zero shortcut and the EX bypass bus that stalls
// dependent readers while the divide is still iterating.
module exe_div_stage
   import exe_div_stage_pkg::*;
#(
   parameter int DIV_ITER = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     flush,
   input  logic                     id_valid,
   output logic                     ex_allowin,
   input  logic [1:0]               div_op,
   input  logic [31:0]              src1,
   input  logic [31:0]              src2,
   input  logic [4:0]               id_rf_waddr,
   input  logic                     id_rf_we,
   output logic                     ex_to_mem_valid,
   input  logic                     mem_allowin,
   output logic [31:0]              ex_result,
   output logic [4:0]               ex_rf_waddr,
   output logic                     ex_rf_we,
   output logic [EX_BYPASS_LEN-1:0] EX_bypass_bus
);

   div_state_e  state_q, state_d;
   logic [1:0]  op_q, op_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        we_q, we_d;
   logic        q_neg_q, q_neg_d;
   logic        r_neg_q, r_neg_d;
   logic [31:0] result_q, result_d;

   logic        sign1, sign2;
   logic [31:0] mag1, mag2;
   logic        div_zero;
   logic        accept;
   logic        core_start;
   logic        core_done;
   logic [31:0] core_q, core_r;
   logic [31:0] final_res;

   div_core #(
      .DIV_ITER (DIV_ITER)
   ) u_core (
      .clk       (clk),
      .resetn    (resetn),
      .kill      (flush),
      .start     (core_start),
      .dividend  (mag1),
      .divisor   (mag2),
      .done      (core_done),
      .quotient  (core_q),
      .remainder (core_r)
   );

   // Next-state, operand latching and result capture; flush overrides all.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      waddr_d    = waddr_q;
      we_d       = we_q;
      q_neg_d    = q_neg_q;
      r_neg_d    = r_neg_q;
      result_d   = result_q;
      core_start = 1'b0;
      sign1      = div_op[DIV_OP_SIGNED] & src1[31];
      sign2      = div_op[DIV_OP_SIGNED] & src2[31];
      mag1       = neg_if(src1, sign1);
      mag2       = neg_if(src2, sign2);
      div_zero   = (src2 == 32'd0);
      ex_allowin = ~flush & ((state_q == DIV_IDLE) |
                             ((state_q == DIV_DONE) & mem_allowin));
      accept     = id_valid & ex_allowin;
      final_res  = op_q[DIV_OP_REM] ? neg_if(core_r, r_neg_q)
                                    : neg_if(core_q, q_neg_q);
      if (flush) begin
         state_d = DIV_IDLE;
         we_d    = 1'b0;
      end else if (accept) begin
         op_d       = div_op;
         waddr_d    = id_rf_waddr;
         we_d       = id_rf_we;
         q_neg_d    = sign1 ^ sign2;
         r_neg_d    = sign1;
         core_start = ~div_zero;
         if (div_zero) begin
            state_d  = DIV_DONE;
            result_d = div_op[DIV_OP_REM] ? src1 : 32'hFFFF_FFFF;
         end else begin
            state_d = DIV_BUSY;
         end
      end else begin
         case (state_q)
            DIV_IDLE: state_d = DIV_IDLE;
            DIV_BUSY: begin
               if (core_done) begin
                  state_d  = DIV_DONE;
                  result_d = final_res;
               end
            end
            DIV_DONE: begin
               if (mem_allowin) begin
                  state_d = DIV_IDLE;
               end
            end
            default:  state_d = DIV_IDLE;
         endcase
      end
   end

   // State and latched-operation registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= DIV_IDLE;
         op_q     <= 2'b00;
         waddr_q  <= 5'd0;
         we_q     <= 1'b0;
         q_neg_q  <= 1'b0;
         r_neg_q  <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         waddr_q  <= waddr_d;
         we_q     <= we_d;
         q_neg_q  <= q_neg_d;
         r_neg_q  <= r_neg_d;
         result_q <= result_d;
      end
   end

   assign ex_to_mem_valid = (state_q == DIV_DONE) & ~flush;
   assign ex_result       = result_q;
   assign ex_rf_waddr     = waddr_q;
   assign ex_rf_we        = we_q;
   assign EX_bypass_bus   = {1'b0,
                             waddr_q,
                             (state_q != DIV_IDLE) & we_q,
                             (state_q == DIV_BUSY),
                             1'b0,
                             (state_q == DIV_DONE) ? result_q : 32'd0};

endmodule

// File: tb/tb_exe_div_stage.sv
// Self-checking bench for exe_div_stage: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_exe_div_stage;

   logic        clk;
   logic        resetn;
   logic        flush;
   logic        id_valid;
   logic        ex_allowin;
   logic [1:0]  div_op;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [4:0]  id_rf_waddr;
   logic        id_rf_we;
   logic        ex_to_mem_valid;
   logic        mem_allowin;
   logic [31:0] ex_result;
   logic [4:0]  ex_rf_waddr;
   logic        ex_rf_we;
   logic [40:0] EX_bypass_bus;

   int n_vec = 0;
   int n_err = 0;

   exe_div_stage #(.DIV_ITER(32)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .flush           (flush),
      .id_valid        (id_valid),
      .ex_allowin      (ex_allowin),
      .div_op          (div_op),
      .src1            (src1),
      .src2            (src2),
      .id_rf_waddr     (id_rf_waddr),
      .id_rf_we        (id_rf_we),
      .ex_to_mem_valid (ex_to_mem_valid),
      .mem_allowin     (mem_allowin),
      .ex_result       (ex_result),
      .ex_rf_waddr     (ex_rf_waddr),
      .ex_rf_we        (ex_rf_we),
      .EX_bypass_bus   (EX_bypass_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: 64-bit integer arithmetic, truncating division.
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return op[0] ? a : 32'hFFFF_FFFF;
      if (op[1]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return op[0] ? r[31:0] : q[31:0];
   endfunction

   // Present one op, wait for accept, then count cycles until DONE.
   // lat = cycles after the accepting edge until valid; 40 means timeout.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa, input logic we,
                         output logic [31:0] res, output int lat, output int mul_ones, output int waits);
      div_op = op; src1 = a; src2 = b; id_rf_waddr = wa; id_rf_we = we; id_valid = 1'b1;
      #1;
      waits = 0;
      while (!ex_allowin && waits < 50) begin
         @(posedge clk); #1; waits++;
      end
      @(posedge clk); #1;
      id_valid = 1'b0;
      src1 = $urandom; src2 = $urandom;
      lat = 1; mul_ones = 0;
      while (!ex_to_mem_valid && lat < 40) begin
         if (EX_bypass_bus[33]) mul_ones++;
         @(posedge clk); #1; lat++;
      end
      res = ex_result;
   endtask

   task automatic test_reset();
      resetn = 1'b0; flush = 1'b0; id_valid = 1'b0; mem_allowin = 1'b1;
      div_op = 2'b00; src1 = 32'd0; src2 = 32'd0; id_rf_waddr = 5'd0; id_rf_we = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (ex_allowin !== 1'b1) begin n_err++; $display("[TB] FAIL reset_allowin got %b want 1", ex_allowin); end
      n_vec++; if (ex_to_mem_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got %b want 0", ex_to_mem_valid); end
      n_vec++; if (EX_bypass_bus !== 41'd0) begin n_err++; $display("[TB] FAIL reset_bus got %h want 0", EX_bypass_bus); end
      n_vec++; if (ex_result !== 32'd0 || ex_rf_we !== 1'b0 || ex_rf_waddr !== 5'd0) begin
         n_err++; $display("[TB] FAIL reset_regs got res=%h we=%b wa=%0d want 0", ex_result, ex_rf_we, ex_rf_waddr); end
      resetn = 1'b1;
   endtask

   task automatic test_unsigned();
      logic [31:0] r; int lat, mo, w;
      run_op(2'b00, 32'd7, 32'd2, 5'd3, 1'b1, r, lat, mo, w);
      n_vec++; if (r !== 32'd3) begin n_err++; $display("[TB] FAIL udiv_q got %h want 3", r); end
      n_vec++; if (lat !== 33) begin n_err++; $display("[TB] FAIL udiv_latency got %0d want 33", lat); end
      n_vec++; if (mo !== 32) begin n_err++; $display("[TB] FAIL udiv_mul_cycles got %0d want 32", mo); end
      n_vec++; if (EX_bypass_bus[33] !== 1'b0) begin n_err++; $display("[TB] FAIL udiv_mul_done got %b want 0", EX_bypass_bus[33]); end
      n_vec++; if (EX_bypass_bus !== {1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'd3}) begin
         n_err++; $display("[TB] FAIL udiv_bus got %h want %h", EX_bypass_bus, {1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 32'd3}); end
      run_op(2'b01, 32'd7, 32'd2, 5'd4, 1'b1, r, lat, mo, w);
      n_vec++; if (r !== 32'd1) begin n_err++; $display("[TB] FAIL urem got %h want 1", r); end
   endtask

   task automatic test_signed();
      logic [31:0] r; int lat, mo, w;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, r, lat, mo, w);
      n_vec++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("[TB] FAIL sdiv_q got %h want fffffffd", r); end
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd5, 1'b1, r, lat, mo, w);
      n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("[TB] FAIL srem got %h want ffffffff", r); end
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, r, lat, mo, w);
      n_vec++; if (r !== 32'h8000_0000) begin n_err++; $display("[TB] FAIL ovf_q got %h want 80000000", r); end
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 1'b1, r, lat, mo, w);
      n_vec++; if (r !== 32'd0) begin n_err++; $display("[TB] FAIL ovf_r got %h want 0", r); end
   endtask

   task automatic test_div_zero();
      logic [31:0] r; int lat, mo, w;
      for (int op = 0; op < 4; op++) begin
         run_op(2'(op), 32'd5, 32'd0, 5'd7, 1'b1, r, lat, mo, w);
         n_vec++; if (r !== (op[0] ? 32'd5 : 32'hFFFF_FFFF)) begin
            n_err++; $display("[TB] FAIL div0_result op=%0d got %h want %h", op, r, op[0] ? 32'd5 : 32'hFFFF_FFFF); end
         n_vec++; if (lat !== 1) begin n_err++; $display("[TB] FAIL div0_latency op=%0d got %0d want 1", op, lat); end
      end
   endtask

   task automatic test_flush();
      logic [31:0] r; int lat, mo, w;
      div_op = 2'b00; src1 = 32'd1000; src2 = 32'd3; id_rf_waddr = 5'd9; id_rf_we = 1'b1; id_valid = 1'b1;
      #1;
      @(posedge clk); #1;
      id_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      #1;
      n_vec++; if (ex_allowin !== 1'b0) begin n_err++; $display("[TB] FAIL flush_allowin_forced got %b want 0", ex_allowin); end
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      n_vec++; if (EX_bypass_bus[34] !== 1'b0 || EX_bypass_bus[33] !== 1'b0) begin
         n_err++; $display("[TB] FAIL flush_bus got we=%b mul=%b want 0 0", EX_bypass_bus[34], EX_bypass_bus[33]); end
      n_vec++; if (ex_allowin !== 1'b1 || ex_to_mem_valid !== 1'b0) begin
         n_err++; $display("[TB] FAIL flush_idle got allowin=%b valid=%b want 1 0", ex_allowin, ex_to_mem_valid); end
      run_op(2'b00, 32'd9, 32'd3, 5'd10, 1'b1, r, lat, mo, w);
      n_vec++; if (r !== 32'd3 || lat !== 33) begin
         n_err++; $display("[TB] FAIL flush_after got %h lat %0d want 3 lat 33", r, lat); end
   endtask

   task automatic test_reset_mid_busy();
      div_op = 2'b00; src1 = 32'd77; src2 = 32'd5; id_rf_waddr = 5'd11; id_rf_we = 1'b1; id_valid = 1'b1;
      #1;
      @(posedge clk); #1;
      id_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      resetn = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      n_vec++; if (EX_bypass_bus !== 41'd0 || ex_allowin !== 1'b1) begin
         n_err++; $display("[TB] FAIL rst_busy got bus=%h allowin=%b want 0 1", EX_bypass_bus, ex_allowin); end
   endtask

   task automatic test_backpressure();
      logic [31:0] r; int lat, mo, w;
      mem_allowin = 1'b0;
      run_op(2'b00, 32'd100, 32'd7, 5'd12, 1'b1, r, lat, mo, w);
      n_vec++; if (r !== 32'd14) begin n_err++; $display("[TB] FAIL bp_result got %h want e", r); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_vec++; if (ex_result !== 32'd14 || ex_to_mem_valid !== 1'b1 || ex_allowin !== 1'b0 || ex_rf_waddr !== 5'd12) begin
            n_err++; $display("[TB] FAIL bp_hold cyc=%0d got res=%h valid=%b allowin=%b wa=%0d want e 1 0 12",
                              i, ex_result, ex_to_mem_valid, ex_allowin, ex_rf_waddr); end
      end
      mem_allowin = 1'b1;
      run_op(2'b01, 32'd50, 32'd6, 5'd13, 1'b1, r, lat, mo, w);
      n_vec++; if (w !== 0) begin n_err++; $display("[TB] FAIL bp_release_accept got %0d waits want 0", w); end
      n_vec++; if (r !== 32'd2 || lat !== 33) begin n_err++; $display("[TB] FAIL bp_next got %h lat %0d want 2 lat 33", r, lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] r; int lat, mo, w;
      run_op(2'b00, 32'd81, 32'd9, 5'd14, 1'b1, r, lat, mo, w);
      run_op(2'b00, 32'd64, 32'd8, 5'd15, 1'b0, r, lat, mo, w);
      n_vec++; if (w !== 0) begin n_err++; $display("[TB] FAIL b2b_accept got %0d waits want 0", w); end
      n_vec++; if (r !== 32'd8 || EX_bypass_bus[34] !== 1'b0) begin
         n_err++; $display("[TB] FAIL b2b_result got %h we=%b want 8 0", r, EX_bypass_bus[34]); end
   endtask

   task automatic test_random();
      logic [31:0] r, a, b, exp; logic [1:0] op; logic [4:0] wa; logic we; int lat, mo, w;
      for (int i = 0; i < 30; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a = 32'h8000_0000;
            1:       a = $urandom_range(0, 1000);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         wa = 5'($urandom); we = 1'($urandom);
         exp = ref_div(op, a, b);
         run_op(op, a, b, wa, we, r, lat, mo, w);
         n_vec++; if (r !== exp) begin
            n_err++; $display("[TB] FAIL rand_result op=%0d a=%h b=%h got %h want %h", op, a, b, r, exp); end
         n_vec++; if (lat !== ((b == 32'd0) ? 1 : 33)) begin
            n_err++; $display("[TB] FAIL rand_latency b=%h got %0d want %0d", b, lat, (b == 32'd0) ? 1 : 33); end
         n_vec++; if (ex_rf_waddr !== wa || ex_rf_we !== we || EX_bypass_bus[39:35] !== wa || EX_bypass_bus[34] !== we) begin
            n_err++; $display("[TB] FAIL rand_dest got wa=%0d we=%b want wa=%0d we=%b", ex_rf_waddr, ex_rf_we, wa, we); end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_flush();
      test_reset_mid_busy();
      test_backpressure();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
